// File: rtl/kamus_lsu_ctrl.sv
// kamus_lsu_ctrl: load/store sequencer between EX and the data-memory port.
// Optional feature macro: KAMUS_LSU_MISALIGNED_SPLIT_EN (splits word-crossing accesses in two).
module kamus_lsu_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_store_i,
   input  logic [1:0]        req_width_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   output logic              rsp_err_o,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              data_req_o,
   input  logic              data_gnt_i,
   output logic              data_we_o,
   output logic [3:0]        data_be_o,
   output logic [ADDR_W-1:0] data_addr_o,
   output logic [DATA_W-1:0] data_wdata_o,
   input  logic              data_rvalid_i,
   input  logic [DATA_W-1:0] data_rdata_i,
   input  logic              data_err_i,
   output logic              busy_o,
   output logic [2:0]        dbg_state_o
);

`ifdef KAMUS_LSU_MISALIGNED_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   // Handshakes: a request transfers on a cycle with req_valid_i && req_ready_o; data_req_o and its
   // payload stay stable until a cycle with data_gnt_i; rsp_valid_o is a one-cycle pulse, never stalled.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ1  = 3'd1,
      S_WAIT1 = 3'd2,
      S_REQ2  = 3'd3,
      S_WAIT2 = 3'd4,
      S_RESP  = 3'd5
   } state_e;

   state_e              state, state_n;
   logic                store_q, unsigned_q, split_q;
   logic [1:0]          width_q, off_q;
   logic [ADDR_W-1:0]   addr_hi_q;
   logic [3:0]          be_hi_q;
   logic [DATA_W-1:0]   wdata_hi_q, rdata_lo_q;

   logic [1:0]          off;
   logic [7:0]          be_wide;
   logic [2*DATA_W-1:0] wdata_wide;
   logic [ADDR_W-1:0]   word_addr;
   logic                width_bad, misaligned, reject;
   logic                accept, launch, second;
   logic                rsp_err_n;
   logic [DATA_W-1:0]   rsp_rdata_n;

   assign req_ready_o = (state == S_IDLE);
   assign busy_o      = (state != S_IDLE);
   assign dbg_state_o = state;

   // merged is {second word[23:0], first word}; only 56 bits can reach the result.
   function automatic logic [DATA_W-1:0] extend(input logic [55:0] merged, input logic [1:0] sh,
                                                input logic [1:0] w, input logic u);
      logic [31:0] s;
      s = merged[{sh, 3'b000} +: 32];
      case (w)
         2'b00:   extend = u ? {24'b0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
         2'b01:   extend = u ? {16'b0, s[15:0]} : {{16{s[15]}}, s[15:0]};
         default: extend = s;
      endcase
   endfunction

   always_comb begin
      off        = req_addr_i[1:0];
      word_addr  = {req_addr_i[ADDR_W-1:2], 2'b00};
      case (req_width_i)
         2'b00:   be_wide = 8'h01 << off;
         2'b01:   be_wide = 8'h03 << off;
         default: be_wide = 8'h0f << off;
      endcase
      wdata_wide = {{DATA_W{1'b0}}, req_wdata_i} << {off, 3'b000};
      width_bad  = (req_width_i == 2'b11);
      misaligned = ((req_width_i == 2'b01) && off[0]) ||
                   ((req_width_i == 2'b10) && (off != 2'b00));
      reject     = width_bad || (misaligned && !SPLIT_EN);
   end

   always_comb begin
      state_n     = state;
      accept      = 1'b0;
      launch      = 1'b0;
      second      = 1'b0;
      rsp_err_n   = 1'b0;
      rsp_rdata_n = '0;
      case (state)
         S_IDLE: begin
            if (req_valid_i) begin
               accept    = 1'b1;
               launch    = !reject;
               rsp_err_n = reject;
               state_n   = reject ? S_RESP : S_REQ1;
            end
         end
         S_REQ1: if (data_gnt_i) state_n = S_WAIT1;
         S_WAIT1: begin
            if (data_rvalid_i) begin
               if (data_err_i) begin
                  rsp_err_n = 1'b1;
                  state_n   = S_RESP;
               end else if (SPLIT_EN && split_q) begin
                  second  = 1'b1;
                  state_n = S_REQ2;
               end else begin
                  rsp_rdata_n = store_q ? '0 : extend({24'b0, data_rdata_i}, off_q, width_q, unsigned_q);
                  state_n     = S_RESP;
               end
            end
         end
         S_REQ2: if (data_gnt_i) state_n = S_WAIT2;
         S_WAIT2: begin
            if (data_rvalid_i) begin
               rsp_err_n = data_err_i;
               if (!store_q && !data_err_i)
                  rsp_rdata_n = extend({data_rdata_i[23:0], rdata_lo_q}, off_q, width_q, unsigned_q);
               state_n = S_RESP;
            end
         end
         S_RESP:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         store_q      <= 1'b0;
         unsigned_q   <= 1'b0;
         split_q      <= 1'b0;
         width_q      <= 2'b00;
         off_q        <= 2'b00;
         addr_hi_q    <= '0;
         be_hi_q      <= 4'b0;
         wdata_hi_q   <= '0;
         rdata_lo_q   <= '0;
         rsp_valid_o  <= 1'b0;
         rsp_err_o    <= 1'b0;
         rsp_rdata_o  <= '0;
         data_req_o   <= 1'b0;
         data_we_o    <= 1'b0;
         data_be_o    <= 4'b0;
         data_addr_o  <= '0;
         data_wdata_o <= '0;
      end else begin
         state       <= state_n;
         rsp_valid_o <= (state_n == S_RESP);
         rsp_err_o   <= rsp_err_n;
         rsp_rdata_o <= rsp_rdata_n;
         data_req_o  <= (state_n == S_REQ1) || (state_n == S_REQ2);
         if (accept) begin
            store_q    <= req_store_i;
            unsigned_q <= req_unsigned_i;
            width_q    <= req_width_i;
            off_q      <= off;
            split_q    <= |be_wide[7:4];
            addr_hi_q  <= word_addr + ADDR_W'(4);
            be_hi_q    <= be_wide[7:4];
            wdata_hi_q <= wdata_wide[2*DATA_W-1:DATA_W];
         end
         // Bus payload is loaded on entry to a REQ state and cleared once the request is granted.
         if (launch) begin
            data_we_o    <= req_store_i;
            data_be_o    <= be_wide[3:0];
            data_addr_o  <= word_addr;
            data_wdata_o <= wdata_wide[DATA_W-1:0];
         end else if (second) begin
            rdata_lo_q   <= data_rdata_i;
            data_we_o    <= store_q;
            data_be_o    <= be_hi_q;
            data_addr_o  <= addr_hi_q;
            data_wdata_o <= wdata_hi_q;
         end else if (state_n != S_REQ1 && state_n != S_REQ2) begin
            data_we_o    <= 1'b0;
            data_be_o    <= 4'b0;
            data_addr_o  <= '0;
            data_wdata_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_kamus_lsu_ctrl.sv
// Directed bench for kamus_lsu_ctrl: a bus responder model, a request driver and a response scoreboard.
// Build with +define+KAMUS_LSU_MISALIGNED_SPLIT_EN to exercise the split-access variant.
module tb_kamus_lsu_ctrl;
   localparam int RW = 41; // {latency[7:0], err, rdata[31:0]}

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_store, req_unsigned;
   logic [1:0]  req_width;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready_o, rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        data_req_o, data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o, data_wdata_o;
   logic        data_gnt, data_rvalid, data_err;
   logic [31:0] data_rdata;
   logic        busy_o;
   logic [2:0]  dbg_state_o;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;
   logic late_rvalid;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          gnt_dly;
      logic        no_rsp;
   } bus_t;

   logic [RW-1:0] exp_q[$];
   int            acc_q[$];
   bus_t          bus_q[$];

   kamus_lsu_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_store_i(req_store),
      .req_width_i(req_width), .req_unsigned_i(req_unsigned), .req_addr_i(req_addr),
      .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
      .data_req_o(data_req_o), .data_gnt_i(data_gnt), .data_we_o(data_we_o),
      .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
      .data_rvalid_i(data_rvalid), .data_rdata_i(data_rdata), .data_err_i(data_err),
      .busy_o(busy_o), .dbg_state_o(dbg_state_o)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                           input int dly, input logic no_rsp);
      bus_t b;
      b.we = we; b.be = be; b.addr = addr; b.wdata = wdata;
      b.rdata = rdata; b.err = err; b.gnt_dly = dly; b.no_rsp = no_rsp;
      bus_q.push_back(b);
   endtask

   // driver: present one request, wait (bounded) for ready, record the expected response
   task automatic issue(input logic st, input logic [1:0] w, input logic u, input logic [31:0] a,
                        input logic [31:0] wd, input logic exp_rsp, input logic err,
                        input logic [31:0] rd, input int lat);
      int t;
      t = 0;
      @(negedge clk);
      while (!req_ready_o && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready_o) begin
         n_vec++;
         n_err++;
         $display("FAIL issue_timeout: req_ready_o stayed 0 for %0d cycles, required 1", t);
      end else begin
         req_valid = 1'b1; req_store = st; req_width = w; req_unsigned = u;
         req_addr = a; req_wdata = wd;
         if (exp_rsp) begin
            exp_q.push_back({8'(lat), err, rd});
            acc_q.push_back(cyc);
         end
         @(posedge clk);
         #1;
         req_valid = 1'b0; req_store = 1'b0; req_width = 2'b00; req_unsigned = 1'b0;
         req_addr = '0; req_wdata = '0;
      end
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || bus_q.size() != 0) && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) begin
         n_vec++;
         n_err++;
         $display("FAIL drain_timeout: %0d responses and %0d bus accesses outstanding, required 0",
                  exp_q.size(), bus_q.size());
      end
   endtask

   // bus responder: checks each request payload, grants after gnt_dly cycles, answers next cycle
   initial begin : responder
      bus_t b;
      logic known;
      data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0; data_err = 1'b0;
      forever begin
         @(negedge clk);
         data_rvalid = 1'b0; data_err = 1'b0; data_rdata = '0;
         if (late_rvalid) begin
            late_rvalid = 1'b0;
            data_rvalid = 1'b1;
            data_rdata  = 32'h5A5A_5A5A;
         end else if (data_req_o) begin
            known = (bus_q.size() != 0);
            if (known) begin
               b = bus_q.pop_front();
               chk("bus_addr", 72'(data_addr_o), 72'(b.addr));
               chk("bus_be", 72'(data_be_o), 72'(b.be));
               chk("bus_we", 72'(data_we_o), 72'(b.we));
               chk("bus_wdata", 72'(data_wdata_o), 72'(b.wdata));
            end else begin
               n_vec++;
               n_err++;
               $display("FAIL bus_unexpected: got request addr %0h be %b, required no bus request",
                        data_addr_o, data_be_o);
               b.gnt_dly = 0; b.no_rsp = 1'b0; b.rdata = '0; b.err = 1'b0;
               b.we = 1'b0; b.be = 4'b0; b.addr = '0; b.wdata = '0;
            end
            for (int i = 0; i < b.gnt_dly; i++) begin
               data_gnt = 1'b0;
               @(negedge clk);
               if (known)
                  chk("bus_hold", {3'b0, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o},
                      {3'b0, 1'b1, b.we, b.be, b.addr, b.wdata});
            end
            data_gnt = 1'b1;
            @(negedge clk);
            data_gnt = 1'b0;
            if (!b.no_rsp) begin
               data_rvalid = 1'b1;
               data_rdata  = b.rdata;
               data_err    = b.err;
            end
         end
      end
   end

   // scoreboard monitor: every response pulse pops one expectation
   initial begin : monitor
      logic [RW-1:0] e;
      int a;
      forever begin
         @(negedge clk);
         if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL rsp_unexpected: got rsp_valid_o=1 err=%b rdata=%0h, required no response",
                        rsp_err_o, rsp_rdata_o);
            end else begin
               e = exp_q.pop_front();
               a = acc_q.pop_front();
               chk("rsp_err", 72'(rsp_err_o), 72'(e[32]));
               chk("rsp_rdata", 72'(rsp_rdata_o), 72'(e[31:0]));
               chk("rsp_latency", 72'(cyc - a), 72'(e[40:33]));
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      n_vec++;
      n_err++;
      $display("FAIL watchdog: run still active at %0t, required completion", $time);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      rst = 1'b1; late_rvalid = 1'b0;
      req_valid = 1'b0; req_store = 1'b0; req_width = 2'b00; req_unsigned = 1'b0;
      req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_ready", 72'(req_ready_o), 72'(1));
      chk("rst_busy", 72'(busy_o), 72'(0));
      chk("rst_state", 72'(dbg_state_o), 72'(0));
      chk("rst_data_req", 72'(data_req_o), 72'(0));
      chk("rst_data_we", 72'(data_we_o), 72'(0));
      chk("rst_data_be", 72'(data_be_o), 72'(0));
      chk("rst_data_addr", 72'(data_addr_o), 72'(0));
      chk("rst_data_wdata", 72'(data_wdata_o), 72'(0));
      chk("rst_rsp_valid", 72'(rsp_valid_o), 72'(0));
      chk("rst_rsp_err", 72'(rsp_err_o), 72'(0));
      chk("rst_rsp_rdata", 72'(rsp_rdata_o), 72'(0));

      // LW aligned, immediate grant
      push_bus(1'b0, 4'b1111, 32'h100, 32'h0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'hDEAD_BEEF, 3);
      // LB / LBU at byte 3
      push_bus(1'b0, 4'b1000, 32'h200, 32'h0, 32'h80FF_0000, 1'b0, 0, 1'b0);
      issue(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80, 3);
      push_bus(1'b0, 4'b1000, 32'h200, 32'h0, 32'h80FF_0000, 1'b0, 0, 1'b0);
      issue(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 1'b1, 1'b0, 32'h0000_0080, 3);
      // SH upper half, grant delayed two cycles
      push_bus(1'b1, 4'b1100, 32'h300, 32'hABCD_0000, 32'h1234_5678, 1'b0, 2, 1'b0);
      issue(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000_ABCD, 1'b1, 1'b0, 32'h0, 5);
      // LH signed / LHU upper half
      push_bus(1'b0, 4'b1100, 32'h300, 32'h0, 32'h8001_1234, 1'b0, 0, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 32'h302, 32'h0, 1'b1, 1'b0, 32'hFFFF_8001, 3);
      push_bus(1'b0, 4'b1100, 32'h700, 32'h0, 32'hF00D_1234, 1'b0, 1, 1'b0);
      issue(1'b0, 2'b01, 1'b1, 32'h702, 32'h0, 1'b1, 1'b0, 32'h0000_F00D, 4);
      // SB lane 2
      push_bus(1'b1, 4'b0100, 32'h800, 32'h00EE_0000, 32'h0, 1'b0, 0, 1'b0);
      issue(1'b1, 2'b00, 1'b0, 32'h802, 32'h0000_00EE, 1'b1, 1'b0, 32'h0, 3);
      // SW with bus error
      push_bus(1'b1, 4'b1111, 32'h500, 32'hCAFE_F00D, 32'h0, 1'b1, 0, 1'b0);
      issue(1'b1, 2'b10, 1'b0, 32'h500, 32'hCAFE_F00D, 1'b1, 1'b1, 32'h0, 3);
      // illegal width: error without bus activity
      issue(1'b0, 2'b11, 1'b0, 32'h700, 32'h0, 1'b1, 1'b1, 32'h0, 1);
`ifdef KAMUS_LSU_MISALIGNED_SPLIT_EN
      push_bus(1'b0, 4'b1110, 32'h400, 32'h0, 32'h4433_2211, 1'b0, 0, 1'b0);
      push_bus(1'b0, 4'b0001, 32'h404, 32'h0, 32'h8877_6655, 1'b0, 0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h401, 32'h0, 1'b1, 1'b0, 32'h5544_3322, 5);
      push_bus(1'b0, 4'b0110, 32'h200, 32'h0, 32'h00A5_B600, 1'b0, 0, 1'b0);
      issue(1'b0, 2'b01, 1'b0, 32'h201, 32'h0, 1'b1, 1'b0, 32'hFFFF_A5B6, 3);
      push_bus(1'b1, 4'b1000, 32'h500, 32'h4400_0000, 32'h0, 1'b0, 0, 1'b0);
      push_bus(1'b1, 4'b0111, 32'h504, 32'h0011_2233, 32'h0, 1'b0, 1, 1'b0);
      issue(1'b1, 2'b10, 1'b0, 32'h503, 32'h1122_3344, 1'b1, 1'b0, 32'h0, 6);
`else
      issue(1'b0, 2'b10, 1'b0, 32'h401, 32'h0, 1'b1, 1'b1, 32'h0, 1);
      issue(1'b0, 2'b01, 1'b0, 32'h201, 32'h0, 1'b1, 1'b1, 32'h0, 1);
      issue(1'b1, 2'b10, 1'b0, 32'h503, 32'h1122_3344, 1'b1, 1'b1, 32'h0, 1);
`endif
      drain();

      // reset while waiting for rvalid: aborted access yields no response, late rvalid ignored
      push_bus(1'b0, 4'b1111, 32'h600, 32'h0, 32'h0, 1'b0, 0, 1'b1);
      issue(1'b0, 2'b10, 1'b0, 32'h600, 32'h0, 1'b0, 1'b0, 32'h0, 0);
      @(negedge clk);
      @(negedge clk);
      chk("wait1_busy", 72'(busy_o), 72'(1));
      chk("wait1_req_low", 72'(data_req_o), 72'(0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", 72'(req_ready_o), 72'(1));
      chk("abort_busy", 72'(busy_o), 72'(0));
      chk("abort_data_req", 72'(data_req_o), 72'(0));
      late_rvalid = 1'b1;
      repeat (4) @(negedge clk);
      chk("late_rvalid_busy", 72'(busy_o), 72'(0));
      push_bus(1'b0, 4'b1111, 32'h900, 32'h0, 32'h0BAD_F00D, 1'b0, 0, 1'b0);
      issue(1'b0, 2'b10, 1'b0, 32'h900, 32'h0, 1'b1, 1'b0, 32'h0BAD_F00D, 3);
      drain();
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
